// File: rtl/lcd_hd44780_responder.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_responder
//
// Target-side model of an HD44780-style character LCD (8-bit bus, 2 lines).
// It sits on the lcd_rs/lcd_rw/lcd_en/lcd_data bus that our LCD writer blocks
// drive, decodes instructions and data writes, and keeps an 80-byte DDRAM,
// the address counter (AC) and the display state. The busy flag is emulated
// with a cycle timer so that writers which ignore it can be caught
// (overrun_cnt). The DDRAM can be read back on rd_addr/rd_data, so on-chip
// self-test logic can check the text that would have been displayed.
//
// Parameters
//   BUSY_SHORT  busy cycles after ordinary instructions and data accesses
//   BUSY_LONG   busy cycles after Clear Display (after the fill) and Return Home
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   lcd_en/rs/rw/data_in     LCD bus from the initiator (asynchronous to clk)
//   lcd_data_out/_oe         read data back to the initiator, and its valid
//   rd_addr -> rd_data       debug DDRAM read (registered, 1-cycle latency;
//                            addresses outside 0x00-0x27/0x40-0x67 read 0x20)
//   addr_cnt, busy           address counter and emulated busy flag
//   display_on..func_seen    mode bits from Display Control/Entry Mode/Function Set
//   disp_offset              display shift offset, 0-39
//   wr_strobe, cmd_err       1-cycle pulses: DDRAM write, invalid Set DDRAM address
//   overrun_cnt              saturating count of transactions dropped while busy
// ---------------------------------------------------------------------------
module lcd_hd44780_responder #(
  parameter int BUSY_SHORT = 2000,
  parameter int BUSY_LONG  = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] addr_cnt,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       func_dl,
  output logic       func_n,
  output logic       func_f,
  output logic       func_seen,
  output logic [5:0] disp_offset,
  output logic       wr_strobe,
  output logic       cmd_err,
  output logic [7:0] overrun_cnt
);

  localparam int TW = (BUSY_LONG > BUSY_SHORT) ? $clog2(BUSY_LONG + 1) : $clog2(BUSY_SHORT + 1);
  // Timer counts down to zero inclusive, so load N-1 for N busy cycles.
  localparam logic [TW-1:0] T_SHORT = TW'(BUSY_SHORT - 1);
  localparam logic [TW-1:0] T_LONG  = TW'(BUSY_LONG - 1);
  localparam logic [6:0]    LAST_IDX = 7'd79;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_CLEAR,
    S_BUSY
  } state_t;

  // -------------------------------------------------------------------------
  // Address helpers. Valid DDRAM addresses are 0x00-0x27 (line 1) and
  // 0x40-0x67 (line 2); both share the rule "low six bits below 40".
  // -------------------------------------------------------------------------
  function automatic logic addr_valid(input logic [6:0] a);
    return a[5:0] < 6'd40;
  endfunction

  // Linear RAM index: line 1 -> 0..39, line 2 -> 40..79. Invalid -> 0 so the
  // array is never indexed out of range.
  function automatic logic [6:0] ddram_idx(input logic [6:0] a);
    if (!addr_valid(a)) return 7'd0;
    return a[6] ? ({1'b0, a[5:0]} + 7'd40) : {1'b0, a[5:0]};
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  function automatic logic [5:0] off_step(input logic [5:0] o, input logic up);
    if (up) return (o == 6'd39) ? 6'd0 : o + 6'd1;
    return (o == 6'd0) ? 6'd39 : o - 6'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Input synchronisers. Stage 3 of en gives the falling-edge detect; stage 3
  // of rs/rw/data holds the value sampled while en was still high.
  // -------------------------------------------------------------------------
  logic       en_s1_q, en_s2_q, en_s3_q;
  logic       rs_s1_q, rs_s2_q, rs_s3_q;
  logic       rw_s1_q, rw_s2_q, rw_s3_q;
  logic [7:0] dat_s1_q, dat_s2_q, dat_s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s1_q  <= 1'b0;
      en_s2_q  <= 1'b0;
      en_s3_q  <= 1'b0;
      rs_s1_q  <= 1'b0;
      rs_s2_q  <= 1'b0;
      rs_s3_q  <= 1'b0;
      rw_s1_q  <= 1'b0;
      rw_s2_q  <= 1'b0;
      rw_s3_q  <= 1'b0;
      dat_s1_q <= 8'h00;
      dat_s2_q <= 8'h00;
      dat_s3_q <= 8'h00;
    end else begin
      en_s1_q  <= lcd_en;
      en_s2_q  <= en_s1_q;
      en_s3_q  <= en_s2_q;
      rs_s1_q  <= lcd_rs;
      rs_s2_q  <= rs_s1_q;
      rs_s3_q  <= rs_s2_q;
      rw_s1_q  <= lcd_rw;
      rw_s2_q  <= rw_s1_q;
      rw_s3_q  <= rw_s2_q;
      dat_s1_q <= lcd_data_in;
      dat_s2_q <= dat_s1_q;
      dat_s3_q <= dat_s2_q;
    end
  end

  logic en_fall;
  logic status_rd;
  assign en_fall   = en_s3_q & ~en_s2_q;
  // Status reads have no side effects, so they are never accepted or dropped.
  assign status_rd = rw_s3_q & ~rs_s3_q;

  // -------------------------------------------------------------------------
  // Control FSM and architectural state
  // -------------------------------------------------------------------------
  state_t        state_q;
  logic [6:0]    clr_cnt_q;
  logic          clr_reset_q;   // fill was started by reset: no long busy after it
  logic [TW-1:0] timer_q;
  logic          busy_q;
  logic [6:0]    ac_q;
  logic [5:0]    offset_q;
  logic          cgram_q;
  logic          display_on_q, cursor_on_q, blink_on_q;
  logic          entry_inc_q, entry_shift_q;
  logic          func_dl_q, func_n_q, func_f_q, func_seen_q;
  logic          wr_strobe_q, cmd_err_q;
  logic [7:0]    overrun_q;
  logic          cmd_rs_q, cmd_rw_q;
  logic [7:0]    cmd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_CLEAR;
      clr_cnt_q     <= 7'd0;
      clr_reset_q   <= 1'b1;
      timer_q       <= '0;
      busy_q        <= 1'b0;
      ac_q          <= 7'd0;
      offset_q      <= 6'd0;
      cgram_q       <= 1'b0;
      display_on_q  <= 1'b0;
      cursor_on_q   <= 1'b0;
      blink_on_q    <= 1'b0;
      entry_inc_q   <= 1'b1;
      entry_shift_q <= 1'b0;
      func_dl_q     <= 1'b0;
      func_n_q      <= 1'b0;
      func_f_q      <= 1'b0;
      func_seen_q   <= 1'b0;
      wr_strobe_q   <= 1'b0;
      cmd_err_q     <= 1'b0;
      overrun_q     <= 8'h00;
      cmd_rs_q      <= 1'b0;
      cmd_rw_q      <= 1'b0;
      cmd_data_q    <= 8'h00;
    end else begin
      wr_strobe_q <= 1'b0;
      cmd_err_q   <= 1'b0;

      if (en_fall && !status_rd && state_q != S_IDLE && overrun_q != 8'hFF)
        overrun_q <= overrun_q + 8'd1;

      case (state_q)
        S_IDLE: begin
          if (en_fall && !status_rd) begin
            cmd_rs_q   <= rs_s3_q;
            cmd_rw_q   <= rw_s3_q;
            cmd_data_q <= dat_s3_q;
            state_q    <= S_EXEC;
            busy_q     <= 1'b1;
          end
        end

        S_EXEC: begin
          // Default exit; Clear overrides the state, Home overrides the timer.
          state_q <= S_BUSY;
          timer_q <= T_SHORT;
          if (cmd_rw_q) begin
            // Data read: data was already presented while en was high.
            ac_q <= ac_step(ac_q, entry_inc_q);
          end else if (cmd_rs_q) begin
            // The RAM write itself happens in the memory block this cycle.
            if (!cgram_q) begin
              wr_strobe_q <= 1'b1;
              ac_q        <= ac_step(ac_q, entry_inc_q);
              if (entry_shift_q)
                offset_q <= off_step(offset_q, entry_inc_q);
            end
          end else begin
            casez (cmd_data_q)
              8'b1???_????: begin
                if (addr_valid(cmd_data_q[6:0])) begin
                  ac_q    <= cmd_data_q[6:0];
                  cgram_q <= 1'b0;
                end else begin
                  cmd_err_q <= 1'b1;
                end
              end
              8'b01??_????: cgram_q <= 1'b1;
              8'b001?_????: begin
                func_dl_q   <= cmd_data_q[4];
                func_n_q    <= cmd_data_q[3];
                func_f_q    <= cmd_data_q[2];
                func_seen_q <= 1'b1;
              end
              8'b0001_????: begin
                if (cmd_data_q[3])
                  offset_q <= off_step(offset_q, cmd_data_q[2]);
                else
                  ac_q <= ac_step(ac_q, cmd_data_q[2]);
              end
              8'b0000_1???: begin
                display_on_q <= cmd_data_q[2];
                cursor_on_q  <= cmd_data_q[1];
                blink_on_q   <= cmd_data_q[0];
              end
              8'b0000_01??: begin
                entry_inc_q   <= cmd_data_q[1];
                entry_shift_q <= cmd_data_q[0];
              end
              8'b0000_001?: begin
                ac_q     <= 7'd0;
                offset_q <= 6'd0;
                cgram_q  <= 1'b0;
                timer_q  <= T_LONG;
              end
              8'b0000_0001: begin
                ac_q        <= 7'd0;
                offset_q    <= 6'd0;
                cgram_q     <= 1'b0;
                entry_inc_q <= 1'b1;
                clr_cnt_q   <= 7'd0;
                clr_reset_q <= 1'b0;
                state_q     <= S_CLEAR;
              end
              default: ;  // 0x00: no operation, short busy
            endcase
          end
        end

        S_CLEAR: begin
          busy_q <= 1'b1;
          if (clr_cnt_q == LAST_IDX) begin
            if (clr_reset_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_BUSY;
              timer_q <= T_LONG;
            end
          end else begin
            clr_cnt_q <= clr_cnt_q + 7'd1;
          end
        end

        S_BUSY: begin
          if (timer_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // DDRAM: one write port (fill or data write), two registered read ports.
  // -------------------------------------------------------------------------
  logic [7:0] mem [0:79];
  logic       mem_we;
  logic [6:0] mem_widx;
  logic [7:0] mem_wdata;
  logic [7:0] rd_data_q;
  logic [7:0] bus_rd_q;

  assign mem_we    = (state_q == S_CLEAR) ||
                     (state_q == S_EXEC && cmd_rs_q && !cmd_rw_q && !cgram_q);
  assign mem_widx  = (state_q == S_CLEAR) ? clr_cnt_q : ddram_idx(ac_q);
  assign mem_wdata = (state_q == S_CLEAR) ? 8'h20 : cmd_data_q;

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_widx] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 8'h00;
      bus_rd_q  <= 8'h00;
    end else begin
      rd_data_q <= addr_valid(rd_addr) ? mem[ddram_idx(rd_addr)] : 8'h20;
      bus_rd_q  <= mem[ddram_idx(ac_q)];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign lcd_data_oe  = en_s2_q & rw_s2_q;
  assign lcd_data_out = !lcd_data_oe ? 8'h00 :
                        (rs_s2_q ? bus_rd_q : {busy_q, ac_q});
  assign rd_data      = rd_data_q;
  assign addr_cnt     = ac_q;
  assign busy         = busy_q;
  assign display_on   = display_on_q;
  assign cursor_on    = cursor_on_q;
  assign blink_on     = blink_on_q;
  assign entry_inc    = entry_inc_q;
  assign entry_shift  = entry_shift_q;
  assign func_dl      = func_dl_q;
  assign func_n       = func_n_q;
  assign func_f       = func_f_q;
  assign func_seen    = func_seen_q;
  assign disp_offset  = offset_q;
  assign wr_strobe    = wr_strobe_q;
  assign cmd_err      = cmd_err_q;
  assign overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder: a table of bus transactions with
// hand-computed expectations, plus hand-written sequences for reset, bus
// reads, the busy-overrun window and reset during a clear.
module tb_lcd_hd44780_responder;

  localparam int BS = 20;
  localparam int BL = 300;

  localparam int SEL_AC    = 0;
  localparam int SEL_FUNC  = 1;
  localparam int SEL_DISP  = 2;
  localparam int SEL_ENTRY = 3;
  localparam int SEL_OFF   = 4;
  localparam int SEL_OVR   = 5;
  localparam int SEL_MEM   = 6;
  localparam int SEL_STB   = 7;
  localparam int SEL_ERR   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_en = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [7:0] rd_data;
  logic [6:0] addr_cnt;
  logic       busy;
  logic       display_on, cursor_on, blink_on;
  logic       entry_inc, entry_shift;
  logic       func_dl, func_n, func_f, func_seen;
  logic [5:0] disp_offset;
  logic       wr_strobe, cmd_err;
  logic [7:0] overrun_cnt;

  lcd_hd44780_responder #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data_in(lcd_data_in),
    .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .rd_addr(rd_addr), .rd_data(rd_data), .addr_cnt(addr_cnt), .busy(busy),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_inc(entry_inc), .entry_shift(entry_shift),
    .func_dl(func_dl), .func_n(func_n), .func_f(func_f), .func_seen(func_seen),
    .disp_offset(disp_offset), .wr_strobe(wr_strobe), .cmd_err(cmd_err),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (cmd_err)   err_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         xact;   // 1: issue a bus write first
    bit         rs;
    logic [7:0] d;
    int         sel;    // which observable to compare
    logic [6:0] a;      // DDRAM address for SEL_MEM
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit x, bit rs, logic [7:0] d, int sel, logic [6:0] a, logic [7:0] e);
    vec_t v;
    v.xact = x; v.rs = rs; v.d = d; v.sel = sel; v.a = a; v.exp = e;
    return v;
  endfunction

  function automatic string sel_name(int sel);
    case (sel)
      SEL_AC:    return "addr_cnt";
      SEL_FUNC:  return "func";
      SEL_DISP:  return "disp_ctrl";
      SEL_ENTRY: return "entry";
      SEL_OFF:   return "disp_offset";
      SEL_OVR:   return "overrun_cnt";
      SEL_MEM:   return "ddram";
      SEL_STB:   return "wr_strobes";
      default:   return "cmd_errs";
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", nm, act);
    end
  endtask

  // One bus cycle: en high for 4 clk, then low for 2 clk. Read data is
  // sampled just before en falls.
  task automatic bus_cycle(input bit rs, input bit rw, input logic [7:0] d,
                           output logic [7:0] rdat, output logic oe);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    rdat = lcd_data_out;
    oe   = lcd_data_oe;
    lcd_en = 1'b0;
    repeat (2) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    repeat (6) @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s_idle_timeout: busy still 1 after %0d cycles, required 0", nm, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_write(input bit rs, input logic [7:0] d, input string nm);
    logic [7:0] r;
    logic oe;
    bus_cycle(rs, 1'b0, d, r, oe);
    wait_idle(nm);
  endtask

  task automatic observe(input int sel, input logic [6:0] a, output logic [7:0] v);
    case (sel)
      SEL_AC:    v = {1'b0, addr_cnt};
      SEL_FUNC:  v = {4'b0, func_seen, func_dl, func_n, func_f};
      SEL_DISP:  v = {5'b0, display_on, cursor_on, blink_on};
      SEL_ENTRY: v = {6'b0, entry_inc, entry_shift};
      SEL_OFF:   v = {2'b0, disp_offset};
      SEL_OVR:   v = overrun_cnt;
      SEL_MEM: begin
        rd_addr = a;
        repeat (2) @(negedge clk);
        v = rd_data;
      end
      SEL_STB:   v = strobe_cnt[7:0];
      default:   v = err_cnt[7:0];
    endcase
  endtask

  task automatic mem_check(input logic [6:0] a, input logic [7:0] e, input string nm);
    logic [7:0] v;
    observe(SEL_MEM, a, v);
    check(nm, v, e);
  endtask

  initial begin
    logic [7:0] v;
    logic       oe;
    string      nm;

    // ---- vector table ----
    vecs.push_back(mk(1, 0, 8'h38, SEL_FUNC,  0, 8'h0E)); // seen,dl,n
    vecs.push_back(mk(1, 0, 8'h08, SEL_DISP,  0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h01, SEL_AC,    0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h06, SEL_ENTRY, 0, 8'h02));
    vecs.push_back(mk(1, 0, 8'h0C, SEL_DISP,  0, 8'h04));
    vecs.push_back(mk(1, 0, 8'h0C, SEL_OVR,   0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h80, SEL_AC,    0, 8'h00));
    vecs.push_back(mk(1, 1, 8'h41, SEL_AC,    0, 8'h01));
    vecs.push_back(mk(1, 1, 8'h42, SEL_AC,    0, 8'h02));
    vecs.push_back(mk(1, 0, 8'hC0, SEL_AC,    0, 8'h40));
    vecs.push_back(mk(1, 1, 8'h5A, SEL_AC,    0, 8'h41));
    vecs.push_back(mk(0, 0, 8'h00, SEL_MEM, 7'h00, 8'h41));
    vecs.push_back(mk(0, 0, 8'h00, SEL_MEM, 7'h01, 8'h42));
    vecs.push_back(mk(0, 0, 8'h00, SEL_MEM, 7'h40, 8'h5A));
    vecs.push_back(mk(0, 0, 8'h00, SEL_STB,   0, 8'd3));
    vecs.push_back(mk(1, 0, 8'hA7, SEL_AC,    0, 8'h27));
    vecs.push_back(mk(1, 1, 8'h31, SEL_AC,    0, 8'h40)); // 0x27 -> 0x40
    vecs.push_back(mk(1, 1, 8'h32, SEL_AC,    0, 8'h41));
    vecs.push_back(mk(0, 0, 8'h00, SEL_MEM, 7'h27, 8'h31));
    vecs.push_back(mk(0, 0, 8'h00, SEL_MEM, 7'h40, 8'h32));
    vecs.push_back(mk(1, 0, 8'h04, SEL_ENTRY, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h80, SEL_AC,    0, 8'h00));
    vecs.push_back(mk(1, 1, 8'h55, SEL_AC,    0, 8'h67)); // 0x00 -> 0x67
    vecs.push_back(mk(0, 0, 8'h00, SEL_MEM, 7'h00, 8'h55));
    vecs.push_back(mk(1, 0, 8'h06, SEL_ENTRY, 0, 8'h02));
    vecs.push_back(mk(1, 0, 8'h10, SEL_AC,    0, 8'h66)); // cursor left
    vecs.push_back(mk(1, 0, 8'h14, SEL_AC,    0, 8'h67)); // cursor right
    vecs.push_back(mk(1, 0, 8'h14, SEL_AC,    0, 8'h00)); // 0x67 -> 0x00
    vecs.push_back(mk(0, 0, 8'h00, SEL_MEM, 7'h28, 8'h20));
    vecs.push_back(mk(0, 0, 8'h00, SEL_MEM, 7'h7F, 8'h20));
    vecs.push_back(mk(1, 0, 8'hA8, SEL_AC,    0, 8'h00)); // invalid address
    vecs.push_back(mk(0, 0, 8'h00, SEL_ERR,   0, 8'd1));
    vecs.push_back(mk(1, 0, 8'h1C, SEL_OFF,   0, 8'd1));
    vecs.push_back(mk(1, 0, 8'h1C, SEL_OFF,   0, 8'd2));
    vecs.push_back(mk(1, 0, 8'h02, SEL_OFF,   0, 8'd0));
    vecs.push_back(mk(1, 0, 8'h18, SEL_OFF,   0, 8'd39)); // 0 -> 39
    vecs.push_back(mk(1, 0, 8'h1C, SEL_OFF,   0, 8'd0));  // 39 -> 0
    vecs.push_back(mk(1, 0, 8'h40, SEL_AC,    0, 8'h00)); // CGRAM mode
    vecs.push_back(mk(1, 1, 8'h77, SEL_AC,    0, 8'h00)); // discarded
    vecs.push_back(mk(0, 0, 8'h00, SEL_MEM, 7'h00, 8'h55));
    vecs.push_back(mk(0, 0, 8'h00, SEL_STB,   0, 8'd6));
    vecs.push_back(mk(1, 0, 8'h80, SEL_AC,    0, 8'h00));
    vecs.push_back(mk(1, 1, 8'h66, SEL_AC,    0, 8'h01));
    vecs.push_back(mk(0, 0, 8'h00, SEL_STB,   0, 8'd7));
    vecs.push_back(mk(1, 0, 8'h07, SEL_ENTRY, 0, 8'h03));
    vecs.push_back(mk(1, 1, 8'h44, SEL_OFF,   0, 8'd1));  // entry shift
    vecs.push_back(mk(1, 0, 8'h06, SEL_ENTRY, 0, 8'h02));
    vecs.push_back(mk(1, 0, 8'hE8, SEL_ERR,   0, 8'd2));  // 0x68 invalid
    vecs.push_back(mk(1, 0, 8'hE7, SEL_AC,    0, 8'h67));

    // ---- reset and power-on fill ----
    repeat (4) @(negedge clk);
    check("reset_addr_cnt", {1'b0, addr_cnt}, 8'h00);
    check("reset_overrun", overrun_cnt, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("fill_busy", busy, 1'b1);
    repeat (95) @(negedge clk);
    check("post_fill_busy", busy, 1'b0);
    check("post_fill_entry_inc", entry_inc, 1'b1);
    check("post_fill_func_seen", func_seen, 1'b0);
    mem_check(7'h00, 8'h20, "fill_00");
    mem_check(7'h27, 8'h20, "fill_27");
    mem_check(7'h40, 8'h20, "fill_40");
    mem_check(7'h67, 8'h20, "fill_67");

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      nm = $sformatf("v%0d_%s", i, sel_name(vecs[i].sel));
      if (vecs[i].xact)
        bus_write(vecs[i].rs, vecs[i].d, nm);
      observe(vecs[i].sel, vecs[i].a, v);
      check(nm, v, vecs[i].exp);
    end

    // ---- bus reads ----
    bus_write(1'b0, 8'h80, "rd_set");
    bus_write(1'b1, 8'h61, "rd_wr");
    bus_write(1'b0, 8'h80, "rd_set2");
    bus_cycle(1'b1, 1'b1, 8'h00, v, oe);
    check("data_read_value", v, 8'h61);
    check("data_read_oe", oe, 1'b1);
    wait_idle("data_read");
    check("data_read_ac", {1'b0, addr_cnt}, 8'h01);
    bus_cycle(1'b0, 1'b1, 8'h00, v, oe);
    check("status_read_idle", v, 8'h01);
    check("oe_released", lcd_data_oe, 1'b0);

    // ---- write dropped while busy after Clear ----
    bus_cycle(1'b0, 1'b0, 8'h01, v, oe);
    repeat (94) @(negedge clk);
    bus_cycle(1'b1, 1'b0, 8'h58, v, oe);
    bus_cycle(1'b0, 1'b1, 8'h00, v, oe);
    check("status_read_busy", v, 8'h80);
    wait_idle("overrun");
    check("overrun_cnt", overrun_cnt, 8'h01);
    check("overrun_ac", {1'b0, addr_cnt}, 8'h00);
    mem_check(7'h00, 8'h20, "overrun_ddram_00");
    mem_check(7'h01, 8'h20, "clear_ddram_01");

    // ---- reset during a clear ----
    bus_cycle(1'b0, 1'b0, 8'h01, v, oe);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_display_on", display_on, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_busy", busy, 1'b1);
    repeat (100) @(negedge clk);
    check("midreset_idle", busy, 1'b0);
    check("midreset_overrun", overrun_cnt, 8'h00);
    check("midreset_entry_inc", entry_inc, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
